coef_stream_unpack: RTL and testbench



---
 rtl/dil_pkg.sv | 17 +
 rtl/sync_fifo_fwft.sv | 63 ++++++
 rtl/coef_stream_unpack.sv | 168 ++++++++++++++++
 tb/tb_coef_stream_unpack.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dil_pkg.sv
// Shared constants and state encoding for the coefficient stream unpacker.
package dil_pkg;

  localparam int COEF_W         = 23;
  localparam int Q              = 8380417;
  localparam int PAIRS_PER_POLY = 128;
  localparam int LANE0_OFF      = 0;
  localparam int LANE1_OFF      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } unpack_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is always on dout.
// rst clears storage and pointers, flush only empties the queue.
module sync_fifo_fwft #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == DEPTH_C);
  assign empty  = (count_r == '0);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/coef_stream_unpack.sv
// Unpacks 64-bit DMA words into buffered coefficient pairs, counts polynomials and checks framing.
// Optional COEF_RANGE_CHECK_EN adds a sticky per-word coefficient range check.
module coef_stream_unpack
  import dil_pkg::*;
#(
  parameter int COEF_W         = dil_pkg::COEF_W,
  parameter int Q              = dil_pkg::Q,
  parameter int FIFO_DEPTH     = 4,
  parameter int PAIRS_PER_POLY = dil_pkg::PAIRS_PER_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        num_polys,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [63:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              Rm_tvalid,
  input  logic              Rm_tready,
  output logic [COEF_W-1:0] data_in_1,
  output logic [COEF_W-1:0] data_in_2,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic              range_err
);

  localparam int PAIR_W = 2 * COEF_W;
  localparam int WC_W   = $clog2(PAIRS_PER_POLY);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(PAIRS_PER_POLY - 1);

  unpack_state_t     state_r;
  logic [WC_W-1:0]   word_cnt_r;
  logic [3:0]        poly_cnt_r;
  logic [3:0]        num_polys_r;
  logic              frame_err_r;
  logic              done_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              accept_s;
  logic              pop_s;
  logic              final_s;
  logic [COEF_W-1:0] lane0_s;
  logic [COEF_W-1:0] lane1_s;
  logic [PAIR_W-1:0] fifo_dout_s;

  assign lane0_s       = s_axis_tdata[LANE0_OFF +: COEF_W];
  assign lane1_s       = s_axis_tdata[LANE1_OFF +: COEF_W];
  assign s_axis_tready = (state_r == RUN) && !fifo_full_s;
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign Rm_tvalid     = !fifo_empty_s;
  assign pop_s         = Rm_tvalid && Rm_tready;
  assign final_s       = (poly_cnt_r == num_polys_r - 4'd1) && (word_cnt_r == WC_LAST);
  assign data_in_1     = fifo_dout_s[COEF_W-1:0];
  assign data_in_2     = fifo_dout_s[PAIR_W-1:COEF_W];
  assign busy          = (state_r != IDLE);
  assign done          = done_r;
  assign frame_err     = frame_err_r;

  sync_fifo_fwft #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push  (accept_s),
    .pop   (pop_s),
    .din   ({lane1_s, lane0_s}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Transfer FSM; a start in any state aborts and restarts, suppressing done for the old transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      word_cnt_r  <= '0;
      poly_cnt_r  <= 4'd0;
      num_polys_r <= 4'd0;
      frame_err_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (start) begin
      word_cnt_r  <= '0;
      poly_cnt_r  <= 4'd0;
      num_polys_r <= num_polys;
      frame_err_r <= 1'b0;
      if (num_polys == 4'd0) begin
        state_r <= DONE;
        done_r  <= 1'b1;
      end else begin
        state_r <= RUN;
        done_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
        end
        RUN: begin
          done_r <= 1'b0;
          if (accept_s) begin
            if (s_axis_tlast != final_s) begin
              frame_err_r <= 1'b1;
            end
            if (word_cnt_r == WC_LAST) begin
              word_cnt_r <= '0;
              poly_cnt_r <= poly_cnt_r + 4'd1;
            end else begin
              word_cnt_r <= word_cnt_r + WC_W'(1);
            end
            if (final_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COEF_RANGE_CHECK_EN
  localparam logic [COEF_W-1:0] Q_C = COEF_W'(Q);

  logic range_bad_s;
  logic range_err_r;

  assign range_bad_s = (lane0_s >= Q_C) || (lane1_s >= Q_C) ||
                       (s_axis_tdata[LANE1_OFF-1:LANE0_OFF+COEF_W] != '0) ||
                       (s_axis_tdata[63:LANE1_OFF+COEF_W] != '0);
  assign range_err   = range_err_r;

  // Sticky range flag, cleared by reset or a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_r <= 1'b0;
    end else if (start) begin
      range_err_r <= 1'b0;
    end else if (accept_s && range_bad_s) begin
      range_err_r <= 1'b1;
    end else begin
      range_err_r <= range_err_r;
    end
  end
`else
  logic unused_upper_s;

  assign unused_upper_s = ^{s_axis_tdata[LANE1_OFF-1:LANE0_OFF+COEF_W],
                            s_axis_tdata[63:LANE1_OFF+COEF_W], Q[0]};
  assign range_err      = 1'b0;
`endif

endmodule

// File: tb/tb_coef_stream_unpack.sv
// Directed self-checking bench for coef_stream_unpack.
module tb_coef_stream_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_polys;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        Rm_tvalid;
  logic        Rm_tready;
  logic [22:0] data_in_1;
  logic [22:0] data_in_2;
  logic        busy;
  logic        done;
  logic        frame_err;
  logic        range_err;

`ifdef COEF_RANGE_CHECK_EN
  localparam logic EXP_RANGE = 1'b1;
`else
  localparam logic EXP_RANGE = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int src_k, nwords, tlast_mode, range_mode, pop_limit;
  int stall_en, stall_left, next_stall;
  int done_cnt, done_cyc, last_pop_cyc, start_cyc;
  int full_at_k, stable_viol, tready_seen;
  int acc_first, acc_last, pop_first;
  int fe_at100, fe_at101, re_at3;
  logic fe_at_done;
  logic prev_stalled;
  logic [45:0] prev_pair;
  logic [45:0] rx_q[$];

  coef_stream_unpack dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_polys     (num_polys),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .Rm_tvalid     (Rm_tvalid),
    .Rm_tready     (Rm_tready),
    .data_in_1     (data_in_1),
    .data_in_2     (data_in_2),
    .busy          (busy),
    .done          (done),
    .frame_err     (frame_err),
    .range_err     (range_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_data(input int k);
    logic [22:0] l0;
    logic [22:0] l1;
    l0 = 23'(k);
    l1 = 23'(k + 256);
    if (range_mode != 0 && k == 3) l0 = 23'd8380417;
    return {9'd0, l1, 9'd0, l0};
  endfunction

  function automatic logic [45:0] exp_pair(input int k);
    logic [63:0] w;
    w = word_data(k);
    return {w[54:32], w[22:0]};
  endfunction

  function automatic logic tlast_for(input int k);
    if (tlast_mode == 1) return (k == 100);
    return (k == nwords - 1);
  endfunction

  task automatic reset_engine(input int np);
    nwords = 128 * np;
    src_k = 0; tlast_mode = 0; range_mode = 0; pop_limit = 1 << 30;
    stall_en = 0; stall_left = 0; next_stall = 0;
    done_cnt = 0; done_cyc = -1; last_pop_cyc = -1;
    full_at_k = -1; stable_viol = 0; tready_seen = 0;
    acc_first = -1; acc_last = -1; pop_first = -1;
    fe_at100 = -1; fe_at101 = -1; re_at3 = -1; fe_at_done = 1'bx;
    prev_stalled = 1'b0; prev_pair = '0;
    rx_q.delete();
  endtask

  task automatic pulse_start(input int np);
    @(negedge clk);
    start = 1'b1;
    num_polys = 4'(np);
    s_axis_tvalid = 1'b0;
    Rm_tready = 1'b0;
    #1;
    start_cyc = cyc;
    cyc++;
  endtask

  // One clock of source/sink stimulus plus recording of observed handshakes.
  task automatic step();
    @(negedge clk);
    start = 1'b0;
    s_axis_tvalid = (src_k < nwords);
    s_axis_tdata = word_data(src_k);
    s_axis_tlast = tlast_for(src_k);
    if (stall_en != 0 && rx_q.size() == next_stall) begin
      stall_left = 10;
      next_stall += 128;
    end
    Rm_tready = (stall_left == 0) && (rx_q.size() < pop_limit);
    if (stall_left > 0) stall_left--;
    #1;
    if (Rm_tvalid && !Rm_tready) begin
      if (prev_stalled && {data_in_2, data_in_1} !== prev_pair) stable_viol++;
      prev_stalled = 1'b1;
      prev_pair = {data_in_2, data_in_1};
    end else begin
      prev_stalled = 1'b0;
    end
    if (Rm_tvalid && Rm_tready) begin
      rx_q.push_back({data_in_2, data_in_1});
      last_pop_cyc = cyc;
      if (pop_first < 0) pop_first = cyc;
    end
    if (s_axis_tready) tready_seen = 1;
    if (busy && !s_axis_tready && full_at_k < 0) full_at_k = src_k;
    if (src_k == 100 && fe_at100 < 0) fe_at100 = int'(frame_err);
    if (src_k == 101 && fe_at101 < 0) fe_at101 = int'(frame_err);
    if (src_k == 3 && re_at3 < 0) re_at3 = int'(range_err);
    if (s_axis_tvalid && s_axis_tready) begin
      if (acc_first < 0) acc_first = cyc;
      acc_last = cyc;
      src_k++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      fe_at_done = frame_err;
    end
    cyc++;
  endtask

  task automatic run_until_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) step();
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_polys = 4'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 64'd0; s_axis_tlast = 1'b0; Rm_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_axis_tready, Rm_tvalid, busy, done, frame_err, range_err, data_in_1, data_in_2} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {s_axis_tready, Rm_tvalid, busy, done, frame_err, range_err, data_in_1, data_in_2});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    reset_engine(2);
    pulse_start(2);
    step();
    checks++;
    if ({busy, s_axis_tready} !== 2'b11) begin
      errors++; $display("FAIL basic_busy_tready_rise: got %b expected 11", {busy, s_axis_tready});
    end
    run_until_done(2000);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (rx_q.size() != 256) begin errors++; $display("FAIL basic_pair_count: got %0d expected 256", rx_q.size()); end
    for (int k = 0; k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_pair(k)) begin
        errors++; $display("FAIL basic_data[%0d]: got %h expected %h", k, rx_q[k], exp_pair(k));
      end
    end
    checks++;
    if (done_cyc != last_pop_cyc + 2) begin
      errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_pop_cyc + 2);
    end
    checks++;
    if (acc_last - acc_first != 255) begin
      errors++; $display("FAIL basic_throughput: got span %0d expected 255", acc_last - acc_first);
    end
    checks++;
    if (pop_first != acc_first + 1) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", pop_first, acc_first + 1);
    end
    checks++;
    if (fe_at_done !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", fe_at_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    reset_engine(2);
    stall_en = 1;
    pulse_start(2);
    run_until_done(3000);
    checks++;
    if (full_at_k != 4) begin errors++; $display("FAIL bp_tready_drop: got %0d words expected 4", full_at_k); end
    checks++;
    if (stable_viol != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stable_viol); end
    checks++;
    if (rx_q.size() != 256) begin errors++; $display("FAIL bp_pair_count: got %0d expected 256", rx_q.size()); end
    for (int k = 0; k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_pair(k)) begin
        errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, rx_q[k], exp_pair(k));
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_framing();
    reset_engine(1);
    tlast_mode = 1;
    pulse_start(1);
    run_until_done(1000);
    checks++;
    if (fe_at100 != 0) begin errors++; $display("FAIL frame_before_100: got %0d expected 0", fe_at100); end
    checks++;
    if (fe_at101 != 1) begin errors++; $display("FAIL frame_after_100: got %0d expected 1", fe_at101); end
    checks++;
    if (fe_at_done !== 1'b1) begin errors++; $display("FAIL frame_at_done: got %b expected 1", fe_at_done); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (rx_q.size() != 128) begin errors++; $display("FAIL frame_pair_count: got %0d expected 128", rx_q.size()); end
  endtask

  task automatic test_zero();
    reset_engine(0);
    pulse_start(0);
    run_until_done(10);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (done_cyc != start_cyc + 1) begin
      errors++; $display("FAIL zero_done_timing: got %0d expected %0d", done_cyc, start_cyc + 1);
    end
    checks++;
    if (tready_seen != 0) begin errors++; $display("FAIL zero_no_tready: got %0d expected 0", tready_seen); end
  endtask

  task automatic test_abort();
    reset_engine(1);
    pulse_start(1);
    for (int i = 0; i < 300 && src_k < 50; i++) step();
    checks++;
    if (src_k != 50 || done_cnt != 0) begin
      errors++; $display("FAIL abort_pre: got words %0d done %0d expected 50 and 0", src_k, done_cnt);
    end
    reset_engine(1);
    pulse_start(1);
    step();
    checks++;
    if (Rm_tvalid !== 1'b0) begin errors++; $display("FAIL abort_flush: got tvalid %b expected 0", Rm_tvalid); end
    run_until_done(1000);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt); end
    checks++;
    if (rx_q.size() != 128) begin errors++; $display("FAIL abort_pair_count: got %0d expected 128", rx_q.size()); end
    for (int k = 0; k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_pair(k)) begin
        errors++; $display("FAIL abort_data[%0d]: got %h expected %h", k, rx_q[k], exp_pair(k));
      end
    end
  endtask

  task automatic test_range();
    reset_engine(1);
    range_mode = 1;
    pulse_start(1);
    run_until_done(1000);
    checks++;
    if (re_at3 != 0) begin errors++; $display("FAIL range_before_3: got %0d expected 0", re_at3); end
    checks++;
    if (range_err !== EXP_RANGE) begin
      errors++; $display("FAIL range_sticky: got %b expected %b", range_err, EXP_RANGE);
    end
    checks++;
    if (rx_q.size() != 128 || rx_q[3][22:0] !== 23'd8380417) begin
      errors++; $display("FAIL range_passthrough: got count %0d expected 128 with word3 lane0 = 8380417", rx_q.size());
    end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL range_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_reset_in_drain();
    reset_engine(1);
    pop_limit = 125;
    pulse_start(1);
    for (int i = 0; i < 400 && src_k < 128; i++) step();
    step();
    step();
    checks++;
    if ({busy, s_axis_tready, Rm_tvalid} !== 3'b101 || rx_q.size() != 125 || done_cnt != 0) begin
      errors++;
      $display("FAIL drain_setup: got busy/tready/tvalid %b pops %0d done %0d expected 101 125 0",
               {busy, s_axis_tready, Rm_tvalid}, rx_q.size(), done_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({s_axis_tready, Rm_tvalid, busy, done, frame_err, range_err, data_in_1, data_in_2} !== 52'd0) begin
      errors++;
      $display("FAIL drain_reset_outputs: got %h expected 0",
               {s_axis_tready, Rm_tvalid, busy, done, frame_err, range_err, data_in_1, data_in_2});
    end
    rst = 1'b0;
    reset_engine(1);
    pulse_start(1);
    run_until_done(1000);
    checks++;
    if (done_cnt != 1 || rx_q.size() != 128) begin
      errors++; $display("FAIL post_reset_xfer: got done %0d pairs %0d expected 1 128", done_cnt, rx_q.size());
    end
    for (int k = 0; k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== exp_pair(k)) begin
        errors++; $display("FAIL post_reset_data[%0d]: got %h expected %h", k, rx_q[k], exp_pair(k));
      end
    end
    checks++;
    if (fe_at_done !== 1'b0) begin errors++; $display("FAIL post_reset_frame: got %b expected 0", fe_at_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_zero();
    test_abort();
    test_range();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
